// File: rtl/pipe_decoder.sv
// pipe_decoder: RV32I decode stage with registered outputs and valid/ready
// handshake. SKID=1 adds a second entry so in_ready is a pure flop output
// and never depends combinationally on out_ready.
module pipe_decoder #(
  parameter int XLEN     = 32,
  parameter int ALUCTL_W = 4,
  parameter int SKID     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd,
  output logic [XLEN-1:0]     imm,
  output logic [2:0]          imm_sel,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic [1:0]          result_src,
  output logic                reg_write,
  output logic                mem_write,
  output logic                is_branch_instr,
  output logic                is_jump,
  output logic                alu_src_imm,
  output logic                illegal
);

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [XLEN-1:0]     imm;
    logic [2:0]          imm_sel;
    logic [ALUCTL_W-1:0] alucontrol;
    logic [1:0]          result_src;
    logic                reg_write;
    logic                mem_write;
    logic                is_branch_instr;
    logic                is_jump;
    logic                alu_src_imm;
    logic                illegal;
  } bundle_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] SEL_I = 3'd0, SEL_S = 3'd1, SEL_B = 3'd2,
                         SEL_U = 3'd3, SEL_J = 3'd4, SEL_NONE = 3'd7;

  // OP / OP-IMM operation code; sub_ok gates SUB to register-register ops
  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt,
                                        input logic sub_ok);
    case (f3)
      3'b000:  alu_fn = (alt && sub_ok) ? 4'd1 : 4'd0;
      3'b001:  alu_fn = 4'd5;
      3'b010:  alu_fn = 4'd9;
      3'b011:  alu_fn = 4'd8;
      3'b100:  alu_fn = 4'd4;
      3'b101:  alu_fn = alt ? 4'd7 : 4'd6;
      3'b110:  alu_fn = 4'd3;
      default: alu_fn = 4'd2;
    endcase
  endfunction

  // Branch comparison code; 010/011 are rejected as illegal before use
  function automatic logic [3:0] br_fn(input logic [2:0] f3);
    case (f3)
      3'b001:  br_fn = 4'd1;
      3'b100:  br_fn = 4'd2;
      3'b101:  br_fn = 4'd3;
      3'b110:  br_fn = 4'd4;
      3'b111:  br_fn = 4'd5;
      default: br_fn = 4'd0;
    endcase
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  bundle_t    dec;
  bundle_t    out_q;
  logic       out_v;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // Combinational decode of the incoming word into a bundle
  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.imm_sel = SEL_NONE;
    dec.illegal = 1'b1;
    case (opc)
      OPC_OP: if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
        dec.illegal    = 1'b0;
        dec.reg_write  = 1'b1;
        dec.alucontrol = ALUCTL_W'(alu_fn(f3, instr[30], 1'b1));
      end
      OPC_OPIMM: begin
        dec.illegal     = 1'b0;
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm_sel     = SEL_I;
        dec.alucontrol  = ALUCTL_W'(alu_fn(f3, instr[30], 1'b0));
      end
      OPC_LOAD: begin
        dec.illegal     = 1'b0;
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm_sel     = SEL_I;
        dec.result_src  = 2'b01;
      end
      OPC_STORE: begin
        dec.illegal     = 1'b0;
        dec.mem_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm_sel     = SEL_S;
      end
      OPC_BRANCH: if (f3 != 3'b010 && f3 != 3'b011) begin
        dec.illegal         = 1'b0;
        dec.is_branch_instr = 1'b1;
        dec.imm_sel         = SEL_B;
        dec.alucontrol      = ALUCTL_W'(br_fn(f3));
      end
      OPC_JAL, OPC_JALR: begin
        dec.illegal     = 1'b0;
        dec.reg_write   = 1'b1;
        dec.is_jump     = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.result_src  = 2'b10;
        dec.imm_sel     = (opc == OPC_JAL) ? SEL_J : SEL_I;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.illegal     = 1'b0;
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm_sel     = SEL_U;
      end
      default: ;
    endcase
    case (dec.imm_sel)
      SEL_I:   dec.imm = XLEN'({{20{instr[31]}}, instr[31:20]});
      SEL_S:   dec.imm = XLEN'({{20{instr[31]}}, instr[31:25], instr[11:7]});
      SEL_B:   dec.imm = XLEN'({{19{instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0});
      SEL_U:   dec.imm = XLEN'({instr[31:12], 12'b0});
      SEL_J:   dec.imm = XLEN'({{11{instr[31]}}, instr[31], instr[19:12],
                                instr[20], instr[30:21], 1'b0});
      default: dec.imm = '0;
    endcase
  end

  generate
    if (SKID != 0) begin : g_skid
      bundle_t skid_q;
      logic    skid_v;

      assign in_ready = !skid_v;

      // Output slot plus one overflow entry; a stalled output parks the new
      // beat in the skid entry, which drains first once out_ready returns
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_v  <= 1'b0;
          out_q  <= '0;
          skid_v <= 1'b0;
          skid_q <= '0;
        end else if (flush) begin
          out_v  <= 1'b0;
          skid_v <= 1'b0;
        end else if (!out_v || out_ready) begin
          if (skid_v) begin
            out_q  <= skid_q;
            out_v  <= 1'b1;
            skid_v <= 1'b0;
          end else begin
            out_v <= in_valid;
            if (in_valid) out_q <= dec;
          end
        end else if (in_valid && !skid_v) begin
          skid_q <= dec;
          skid_v <= 1'b1;
        end
      end
    end else begin : g_reg
      assign in_ready = !out_v || out_ready;

      // Single output register; accepts whenever the slot is free or draining
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_v <= 1'b0;
          out_q <= '0;
        end else if (flush) begin
          out_v <= 1'b0;
        end else if (in_valid && in_ready) begin
          out_q <= dec;
          out_v <= 1'b1;
        end else if (out_ready) begin
          out_v <= 1'b0;
        end
      end
    end
  endgenerate

  assign out_valid       = out_v;
  assign out_pc          = out_q.pc;
  assign rs1             = out_q.rs1;
  assign rs2             = out_q.rs2;
  assign rd              = out_q.rd;
  assign imm             = out_q.imm;
  assign imm_sel         = out_q.imm_sel;
  assign alucontrol      = out_q.alucontrol;
  assign result_src      = out_q.result_src;
  assign reg_write       = out_q.reg_write;
  assign mem_write       = out_q.mem_write;
  assign is_branch_instr = out_q.is_branch_instr;
  assign is_jump         = out_q.is_jump;
  assign alu_src_imm     = out_q.alu_src_imm;
  assign illegal         = out_q.illegal;

endmodule

// File: tb/tb_pipe_decoder.sv
// tb_pipe_decoder: directed + random stimulus, scoreboard of expected
// bundles pushed on input handshake and popped on output handshake.
module tb_pipe_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic [2:0]  imm_sel;
  logic [3:0]  alucontrol;
  logic [1:0]  result_src;
  logic        reg_write, mem_write, is_branch_instr, is_jump, alu_src_imm, illegal;

  int checks = 0;
  int errors = 0;
  logic [93:0] sb[$];
  logic [31:0] pc = 32'h1000;

  pipe_decoder #(.XLEN(32), .ALUCTL_W(4), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .imm_sel(imm_sel), .alucontrol(alucontrol),
    .result_src(result_src), .reg_write(reg_write), .mem_write(mem_write),
    .is_branch_instr(is_branch_instr), .is_jump(is_jump),
    .alu_src_imm(alu_src_imm), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference decode, written from the ISA tables
  function automatic logic [93:0] model(input logic [31:0] w, input logic [31:0] p);
    logic [2:0] f3, sel;
    logic [6:0] f7;
    logic [3:0] alu;
    logic [1:0] rsrc;
    logic [31:0] im, sx;
    logic rw, mw, br, jp, asi, ill;
    f3 = w[14:12]; f7 = w[31:25];
    sel = 3'd7; alu = 4'd0; rsrc = 2'd0;
    rw = 0; mw = 0; br = 0; jp = 0; asi = 0; ill = 1;
    case (w[6:0])
      7'h33: if (f7 == 7'h00 || f7 == 7'h20) begin
        ill = 0; rw = 1;
        case (f3)
          3'd0: alu = w[30] ? 4'd1 : 4'd0;
          3'd1: alu = 4'd5;
          3'd2: alu = 4'd9;
          3'd3: alu = 4'd8;
          3'd4: alu = 4'd4;
          3'd5: alu = w[30] ? 4'd7 : 4'd6;
          3'd6: alu = 4'd3;
          3'd7: alu = 4'd2;
        endcase
      end
      7'h13: begin
        ill = 0; rw = 1; asi = 1; sel = 3'd0;
        case (f3)
          3'd0: alu = 4'd0;
          3'd1: alu = 4'd5;
          3'd2: alu = 4'd9;
          3'd3: alu = 4'd8;
          3'd4: alu = 4'd4;
          3'd5: alu = w[30] ? 4'd7 : 4'd6;
          3'd6: alu = 4'd3;
          3'd7: alu = 4'd2;
        endcase
      end
      7'h03: begin ill = 0; rw = 1; asi = 1; sel = 3'd0; rsrc = 2'b01; end
      7'h23: begin ill = 0; mw = 1; asi = 1; sel = 3'd1; end
      7'h63: if (f3 != 3'd2 && f3 != 3'd3) begin
        ill = 0; br = 1; sel = 3'd2;
        case (f3)
          3'd1: alu = 4'd1;
          3'd4: alu = 4'd2;
          3'd5: alu = 4'd3;
          3'd6: alu = 4'd4;
          3'd7: alu = 4'd5;
          default: alu = 4'd0;
        endcase
      end
      7'h6F: begin ill = 0; rw = 1; jp = 1; asi = 1; rsrc = 2'b10; sel = 3'd4; end
      7'h67: begin ill = 0; rw = 1; jp = 1; asi = 1; rsrc = 2'b10; sel = 3'd0; end
      7'h37, 7'h17: begin ill = 0; rw = 1; asi = 1; sel = 3'd3; end
      default: ;
    endcase
    sx = $signed(w) >>> 20;
    case (sel)
      3'd0: im = sx;
      3'd1: im = {sx[31:5], w[11:7]};
      3'd2: im = {sx[31:12], w[7], w[30:25], w[11:8], 1'b0};
      3'd3: im = {w[31:12], 12'h000};
      3'd4: im = {sx[31:20], w[19:12], w[20], w[30:21], 1'b0};
      default: im = 32'h0;
    endcase
    model = {p, w[19:15], w[24:20], w[11:7], im, sel, alu, rsrc,
             rw, mw, br, jp, asi, ill};
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; edges counts clock edges used
  task automatic send(input logic [31:0] w, output int edges);
    logic acc;
    edges = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    instr = w;
    in_pc = pc;
    pc = pc + 4;
    while (!acc && edges < 50) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      edges++;
    end
    chk("send_accept", {95'd0, acc}, 96'd1);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 8)];
    return w;
  endfunction

  initial begin
    int n, tot;
    logic done;
    done = 1'b0;

    // Scoreboard monitor: sampled on the falling edge, ahead of the transfer edge
    fork
      forever begin
        @(negedge clk);
        if (!rst_n || flush) begin
          sb.delete();
        end else begin
          if (out_valid && out_ready) begin
            chk("sb_nonempty", {64'd0, 32'(sb.size() != 0)}, 96'd1);
            if (sb.size() != 0)
              chk("bundle", {2'b0, out_pc, rs1, rs2, rd, imm, imm_sel, alucontrol,
                   result_src, reg_write, mem_write, is_branch_instr, is_jump,
                   alu_src_imm, illegal}, {2'b0, sb.pop_front()});
          end
          if (in_valid && in_ready) sb.push_back(model(instr, in_pc));
        end
      end
    join_none

    // Reset
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_out_valid", {95'd0, out_valid}, 96'd0);
    chk("rst_in_ready", {95'd0, in_ready}, 96'd1);
    chk("rst_bundle", {out_pc, imm, rd, alucontrol, reg_write, imm_sel},
        96'd0);

    // Directed decodes with out_ready high
    out_ready = 1'b1;
    send(32'h002081B3, n); in_valid = 1'b0;
    chk("add_valid", {95'd0, out_valid}, 96'd1);
    chk("add_fields", {rd, rs1, rs2, alucontrol, reg_write, alu_src_imm, illegal},
        {5'd3, 5'd1, 5'd2, 4'd0, 3'b100});
    tick();
    send(32'h402081B3, n); in_valid = 1'b0;
    chk("sub_alu", {92'd0, alucontrol}, 96'd1);
    tick();
    send(32'h4030D093, n); in_valid = 1'b0;
    chk("srai_alu_imm", {alucontrol, imm[4:0]}, {4'd7, 5'd3});
    tick();
    send(32'hFFF00093, n); in_valid = 1'b0;
    chk("addi_imm", {imm, imm_sel}, {32'hFFFFFFFF, 3'd0});
    tick();
    send(32'hFE000EE3, n); in_valid = 1'b0;
    chk("beq_fields", {imm, imm_sel, is_branch_instr, reg_write},
        {32'hFFFFFFFC, 3'd2, 1'b1, 1'b0});
    tick();
    send(32'h00000000, n); in_valid = 1'b0;
    chk("zero_illegal", {illegal, reg_write, mem_write}, {1'b1, 1'b0, 1'b0});
    tick();
    send(32'h008000EF, n); in_valid = 1'b0;
    chk("jal_fields", {is_jump, result_src, imm}, {1'b1, 2'b10, 32'd8});
    tick();

    // Back-to-back stream of 8 with out_ready low for 3 edges
    fork
      begin
        tot = 0;
        for (int i = 0; i < 8; i++) begin
          send(32'h00000013 | (32'(i) << 20) | (32'(i + 1) << 7), n);
          tot += n;
        end
        in_valid = 1'b0;
        chk("stream_edges", 96'(tot), 96'd10);
      end
      begin
        out_ready = 1'b0;
        tick(); tick();
        chk("stall_in_ready_lo", {95'd0, in_ready}, 96'd0);
        tick();
        chk("stall_in_ready_lo2", {95'd0, in_ready}, 96'd0);
        out_ready = 1'b1;
        tick();
        chk("stall_in_ready_hi", {95'd0, in_ready}, 96'd1);
      end
    join
    repeat (3) tick();
    chk("stream_drained", 96'(sb.size()), 96'd0);

    // Flush with skid full and a new beat offered
    out_ready = 1'b0;
    send(32'h00100093, n);
    send(32'h00200113, n);
    chk("flush_pre_full", {95'd0, in_ready}, 96'd0);
    instr = 32'h00300193; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {95'd0, out_valid}, 96'd0);
    chk("flush_in_ready", {95'd0, in_ready}, 96'd1);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("flush_nothing_out", {95'd0, out_valid}, 96'd0);

    // Reset mid-transfer discards held beats
    out_ready = 1'b0;
    send(32'h00400213, n);
    send(32'h00500293, n);
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_out_valid", {95'd0, out_valid}, 96'd0);
    chk("midrst_bundle", {out_pc, rd, imm}, 96'd0);
    out_ready = 1'b1;
    tick();
    chk("midrst_nothing_out", {95'd0, out_valid}, 96'd0);

    // Random stream with random backpressure and idle gaps
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(rnd_instr(), n);
          if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            tick();
          end
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    tick();
    chk("final_drain", 96'(sb.size()), 96'd0);
    chk("final_idle", {95'd0, out_valid}, 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
